// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 4-digit seven-segment scan driver with frame-synchronous value update.
//   clk        : system clock
//   reset      : asynchronous active-low reset
//   en         : scan enable (0 = display dark, scan position held at digit 0)
//   load       : single-cycle strobe, captures value/dp_mask/blank_mask into the shadow
//   value      : four hex nibbles, digit0 = value[3:0] ... digit3 = value[15:12]
//   dp_mask    : decimal point per digit
//   blank_mask : force digit dark per digit
//   digi       : [11:8] AN3..AN0, [7] DP, [6:0] segments g..a (registered)
//   frame_done : one-cycle pulse on the edge the scan wraps from digit 3 to digit 0
//   pending    : shadow holds a value not yet applied to the display
// Optional build macro: SEG_LEADING_ZERO_BLANK_EN blanks the segments of digits above the
// most significant nonzero nibble (digit 0 is never auto-blanked).
module seg_scan_driver #(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_mask,
  input  logic [3:0]  blank_mask,
  output logic [11:0] digi,
  output logic        frame_done,
  output logic        pending
);

  localparam int unsigned PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [11:0] DIGI_OFF  = ACTIVE_LOW ? 12'hFFF : 12'h000;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
  } disp_t;

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  disp_t         shadow_q, shadow_d;
  disp_t         active_q, active_d;
  logic          pending_q, pending_d;
  logic          frame_done_q, frame_done_d;
  logic [11:0]   digi_q, digi_d;

  // Hex font, active-high gfedcba.
  function automatic logic [6:0] hex_font(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // Digit idx is a leading zero when it and every higher nibble are zero.
  function automatic logic lead_zero(input logic [1:0] idx, input logic [15:0] v);
    logic z;
    case (idx)
      2'd0:    z = 1'b0;
      2'd1:    z = (v[15:4] == 12'h000);
      2'd2:    z = (v[15:8] == 8'h00);
      default: z = (v[15:12] == 4'h0);
    endcase
    return z;
  endfunction
`endif

  // Display word for one digit slot; a blanked digit keeps its anode.
  function automatic logic [11:0] render(input logic [1:0] idx, input disp_t d);
    logic [3:0]  nib;
    logic        seg_off;
    logic        dp_on;
    logic [6:0]  seg;
    logic [11:0] w;
    nib     = d.value[{idx, 2'b00} +: 4];
    seg_off = d.blank[idx];
    dp_on   = d.dp[idx] & ~d.blank[idx];
`ifdef SEG_LEADING_ZERO_BLANK_EN
    seg_off = seg_off | lead_zero(idx, d.value);
`endif
    seg = seg_off ? 7'h00 : hex_font(nib);
    w   = {4'(4'b0001 << idx), dp_on, seg};
    return ACTIVE_LOW ? ~w : w;
  endfunction

  // Scan position, frame-boundary transfer and display word.
  always_comb begin
    logic tick;
    logic boundary;
    presc_d      = presc_q;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    pending_d    = pending_q;
    frame_done_d = 1'b0;
    digi_d       = DIGI_OFF;
    tick         = 1'b0;
    boundary     = 1'b0;

    if (en) begin
      tick     = (presc_q == PRESC_MAX);
      boundary = tick && (idx_q == 2'd3);
      presc_d  = tick ? '0 : presc_q + PW'(1);
      if (tick) idx_d = idx_q + 2'd1;
    end else begin
      presc_d = '0;
      idx_d   = '0;
    end

    frame_done_d = boundary;

    // Transfer uses the old shadow; a coincident load lands in the shadow afterwards.
    if (pending_q && (!en || boundary)) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (load) begin
      shadow_d  = '{value: value, dp: dp_mask, blank: blank_mask};
      pending_d = 1'b1;
    end

    // Rendered from next-state data so the word tracks idx on the same edge.
    if (en) digi_d = render(idx_d, active_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q      <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      digi_q       <= DIGI_OFF;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      digi_q       <= digi_d;
    end
  end

  assign digi       = digi_q;
  assign frame_done = frame_done_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Testbench for seg_scan_driver: stimulus pushes expected post-edge outputs into a queue,
// an independent monitor pops and compares one entry per clock edge.
module tb_seg_scan_driver;

  localparam int unsigned D          = 4;
  localparam bit          AL         = 1'b1;
  localparam logic [11:0] OFF        = 12'hFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_mask = 4'h0;
  logic [3:0]  blank_mask = 4'h0;
  logic [11:0] digi;
  logic        frame_done;
  logic        pending;

  seg_scan_driver #(.SCAN_DIV(D), .ACTIVE_LOW(AL)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .load       (load),
    .value      (value),
    .dp_mask    (dp_mask),
    .blank_mask (blank_mask),
    .digi       (digi),
    .frame_done (frame_done),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] digi;
    logic        fd;
    logic        pend;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  logic [6:0] FONT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference state: enabled-edge count since en rose, plus shadow/active/pending.
  int          n = 0;
  logic [23:0] m_shadow = '0;
  logic [23:0] m_active = '0;
  logic        m_pend = 1'b0;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Expected word for digit slot idx given {value, dp, blank}.
  function automatic logic [11:0] expect_word(input int idx, input logic [23:0] a);
    logic [15:0] v;
    logic [3:0]  dp;
    logic [3:0]  bl;
    bit          segs_off;
    bit          dp_on;
    int          w;
    v  = a[23:8];
    dp = a[7:4];
    bl = a[3:0];
    segs_off = bl[idx];
    dp_on    = dp[idx] && !bl[idx];
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (idx > 0 && (int'(v) >> (4 * idx)) == 0) segs_off = 1'b1;
`endif
    w = (1 << (8 + idx)) | (dp_on ? 'h80 : 0)
      | (segs_off ? 0 : int'(FONT[(int'(v) >> (4 * idx)) & 15]));
    if (AL) w = ~w & 'hFFF;
    return 12'(w);
  endfunction

  // One clock of stimulus; model predicts outputs after the coming posedge.
  task automatic step(input logic r, input logic e, input logic l, input logic [15:0] v,
                      input logic [3:0] dp, input logic [3:0] bl);
    exp_t x;
    bit   bnd;
    @(negedge clk);
    reset = r; en = e; load = l; value = v; dp_mask = dp; blank_mask = bl;
    if (!r) begin
      #1;
      chk("async_reset_digi", digi, OFF);
      chk("async_reset_frame_done", 12'(frame_done), 12'd0);
      chk("async_reset_pending", 12'(pending), 12'd0);
      n = 0; m_shadow = '0; m_active = '0; m_pend = 1'b0;
      x.digi = OFF; x.fd = 1'b0; x.pend = 1'b0;
    end else begin
      bnd = 1'b0;
      if (!e) n = 0;
      else begin
        n++;
        bnd = (n % D == 0) && ((n / D) % 4 == 0);
      end
      if (m_pend && (!e || bnd)) begin
        m_active = m_shadow;
        m_pend   = 1'b0;
      end
      if (l) begin
        m_shadow = {v, dp, bl};
        m_pend   = 1'b1;
      end
      x.digi = e ? expect_word((n / D) % 4, m_active) : OFF;
      x.fd   = bnd;
      x.pend = m_pend;
    end
    sbq.push_back(x);
  endtask

  task automatic run(input logic e, input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b1, e, 1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
    step(1'b1, 1'b1, 1'b1, v, dp, bl);
  endtask

  // Advance until the coming edge is a frame boundary, then load on exactly that edge.
  task automatic load_on_boundary(input logic [15:0] v);
    int k;
    int nn;
    k = 0;
    nn = n + 1;
    while (!((nn % D == 0) && ((nn / D) % 4 == 0)) && k < 64) begin
      run(1'b1, 1);
      k++;
      nn = n + 1;
    end
    do_load(v, 4'h0, 4'h0);
  endtask

  // Monitor: one expected entry per clock edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        x = sbq.pop_front();
        chk("digi", digi, x.digi);
        chk("frame_done", 12'(frame_done), 12'(x.fd));
        chk("pending", 12'(pending), 12'(x.pend));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // Reset, then hold with en=0.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
    run(1'b0, 10);

    // Basic scan of 12AF.
    do_load(16'h12AF, 4'h0, 4'h0);
    run(1'b1, 48);

    // Two loads in one frame: last wins.
    do_load(16'h0000, 4'h0, 4'h0);
    run(1'b1, 3);
    do_load(16'h5555, 4'h0, 4'h0);
    run(1'b1, 48);

    // Load coincident with the boundary edge.
    load_on_boundary(16'h9876);
    run(1'b1, 48);

    // DP and blanking.
    do_load(16'h1234, 4'b0100, 4'b0001);
    run(1'b1, 40);

    // Leading-zero cases.
    do_load(16'h0007, 4'h0, 4'h0);
    run(1'b1, 40);
    do_load(16'h0000, 4'h0, 4'h0);
    run(1'b1, 40);

    // Disable with a pending load, then re-enable.
    step(1'b1, 1'b1, 1'b1, 16'hC0DE, 4'b1010, 4'h0);
    run(1'b0, 3);
    step(1'b1, 1'b0, 1'b1, 16'hBEEF, 4'b0001, 4'b0010);
    run(1'b0, 2);
    run(1'b1, 20);

    // Mid-scan reset.
    run(1'b1, 7);
    step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    run(1'b1, 20);

    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      logic        r, e, l;
      logic [15:0] v;
      r = ($urandom_range(0, 299) != 0);
      e = ($urandom_range(0, 29) != 0);
      l = ($urandom_range(0, 7) == 0);
      v = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      step(r, e, l, v,
           ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom),
           ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0);
    end
    step(1'b1, 1'b1, 1'b0, 16'h0, 4'h0, 4'h0);

    // Drain the scoreboard.
    k = 0;
    while (sbq.size() > 0 && k < 20) begin
      @(posedge clk);
      k++;
    end
    @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d entries left expected 0", sbq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
